alu_issue: RTL and testbench

Execute-stage issue register that sits in front of the combinational ALU. It takes decoded RV32I instruction fields and operands over a valid/ready handshake. It produces the registered ALU operand pair and the 4-bit ALU operation select the ALU consumes, so it is the producer end of the ALU `sel`/operand interface. A two-entry skid buffer gives full throughput with registered `in_ready`.

---
 rtl/alu_issue.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue register ahead of the ALU.
// Decodes RV32I fields into ALU operands/select behind a 2-entry skid buffer.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_sel,
  output logic             out_illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_AND = 4'd2;
  localparam logic [3:0] SEL_OR  = 4'd3;
  localparam logic [3:0] SEL_XOR = 4'd4;
  localparam logic [3:0] SEL_SLL = 4'd5;
  localparam logic [3:0] SEL_SRL = 4'd6;
  localparam logic [3:0] SEL_SRA = 4'd7;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_SKID
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             ill;
  } ent_t;

  state_e state_q, state_d;
  logic   in_ready_q;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;
  ent_t   dec;

  logic is_op, is_opi, is_ui, is_auipc;
  logic is_mem, is_jmp, is_br;
  logic alu_ill, is_shift;
  logic [3:0] alu_sel;

  logic acc, pop;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign is_op    = (in_opcode == OPC_OP);
  assign is_opi   = (in_opcode == OPC_OPIMM);
  assign is_ui    = (in_opcode == OPC_LUI);
  assign is_auipc = (in_opcode == OPC_AUIPC);
  assign is_mem   = (in_opcode == OPC_LOAD)
                  | (in_opcode == OPC_STORE);
  assign is_jmp   = (in_opcode == OPC_JAL)
                  | (in_opcode == OPC_JALR);
  assign is_br    = (in_opcode == OPC_BRANCH);

  always_comb begin
    alu_sel  = SEL_ADD;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    unique case (in_funct3)
      3'b000: begin
        alu_sel = (is_op && in_funct7b5)
                ? SEL_SUB : SEL_ADD;
      end
      3'b001: begin
        alu_sel  = SEL_SLL;
        is_shift = 1'b1;
      end
      3'b100: alu_sel = SEL_XOR;
      3'b101: begin
        alu_sel  = in_funct7b5
                 ? SEL_SRA : SEL_SRL;
        is_shift = 1'b1;
      end
      3'b110: alu_sel = SEL_OR;
      3'b111: alu_sel = SEL_AND;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_op, is_opi: begin
        dec.a   = in_rs1;
        dec.b   = is_op ? in_rs2 : in_imm;
        dec.sel = alu_sel;
        if (is_shift) begin
          dec.b = {{(WIDTH-SHW){1'b0}},
                   dec.b[SHW-1:0]};
        end
        if (alu_ill) begin
          dec     = '0;
          dec.ill = 1'b1;
        end
      end
      is_ui: begin
        dec.b = in_imm;
      end
      is_auipc: begin
        dec.a = in_pc;
        dec.b = in_imm;
      end
      is_mem: begin
        dec.a = in_rs1;
        dec.b = in_imm;
      end
      is_jmp: begin
        dec.a = in_pc;
        dec.b = WIDTH'(4);
      end
      is_br: begin
        dec.a   = in_rs1;
        dec.b   = in_rs2;
        dec.sel = SEL_SUB;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
  end

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = in_ready_q;
  assign acc       = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_SKID);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) state_d = S_FULL;
      end
      S_FULL: begin
        if (acc && !pop) state_d = S_SKID;
        else if (!acc && pop) state_d = S_EMPTY;
      end
      S_SKID: begin
        if (pop) state_d = S_FULL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      S_EMPTY: ld_main_in = acc;
      S_FULL: begin
        ld_main_in = acc & pop;
        ld_skid    = acc & ~pop;
      end
      S_SKID: ld_main_skid = pop;
      default: ;
    endcase
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (ld_main_in)   main_d = dec;
    if (ld_main_skid) main_d = skid_q;
    if (ld_skid)      skid_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue.
// Directed vectors with hand-computed decode results.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_sel;
  logic        out_illegal;

  alu_issue #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_sel(out_sel), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [31:0] a, b;
    logic [3:0]  sel;
    logic        ill;
  } vec_t;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;

  vec_t V[20];
  vec_t cur;
  vec_t q[$];
  int checks = 0;
  int failures = 0;
  int held = 0;
  bit stl = 0;
  logic [31:0] pa, pb;
  logic [3:0]  ps;
  logic        pi;
  bit done = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic send(input int i);
    bit ok;
    int n;
    cur = V[i];
    in_opcode = V[i].op;
    in_funct3 = V[i].f3;
    in_funct7b5 = V[i].f7;
    in_rs1 = V[i].rs1;
    in_rs2 = V[i].rs2;
    in_imm = V[i].imm;
    in_pc = V[i].pc;
    in_valid = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(cur);
  end

  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      held = 0;
      stl = 0;
    end else begin
      chk("in_ready", in_ready, held != 2);
      chk("out_valid", out_valid, held != 0);
      if (stl && out_valid) begin
        chk("stall_a", out_a, pa);
        chk("stall_b", out_b, pb);
        chk("stall_sel", out_sel, ps);
        chk("stall_ill", out_illegal, pi);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = q.pop_front();
          chk("a", out_a, e.a);
          chk("b", out_b, e.b);
          chk("sel", out_sel, e.sel);
          chk("ill", out_illegal, e.ill);
        end
        if (held > 0) held--;
      end
      if (in_valid && in_ready) held++;
      stl = out_valid && !out_ready;
      pa = out_a;
      pb = out_b;
      ps = out_sel;
      pi = out_illegal;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_ov"}, out_valid, 0);
    chk({nm, "_ir"}, in_ready, 1);
    chk({nm, "_a"}, out_a, 0);
    chk({nm, "_b"}, out_b, 0);
    chk({nm, "_sel"}, out_sel, 0);
    chk({nm, "_ill"}, out_illegal, 0);
  endtask

  initial begin
    V[0]  = '{OP, 3'b000, 1'b1, 32'd10, 32'd3, 0, 0,
              32'd10, 32'd3, 4'd1, 1'b0};
    V[1]  = '{OPI, 3'b101, 1'b1, 32'h8000_0000, 0,
              32'h0000_0423, 0,
              32'h8000_0000, 32'd3, 4'd7, 1'b0};
    V[2]  = '{OP, 3'b001, 1'b0, 32'd5, 32'hFFFF_FFE4, 0, 0,
              32'd5, 32'd4, 4'd5, 1'b0};
    V[3]  = '{OPI, 3'b000, 1'b1, 32'd7, 0, 32'd9, 0,
              32'd7, 32'd9, 4'd0, 1'b0};
    V[4]  = '{7'b0110111, 3'b000, 1'b0, 32'h55, 32'h66,
              32'h1234_5000, 0,
              32'd0, 32'h1234_5000, 4'd0, 1'b0};
    V[5]  = '{7'b0010111, 3'b000, 1'b0, 32'd1, 32'd2,
              32'h2000, 32'h100,
              32'h100, 32'h2000, 4'd0, 1'b0};
    V[6]  = '{7'b1101111, 3'b000, 1'b0, 32'd1, 32'd2,
              32'h999, 32'h40,
              32'h40, 32'd4, 4'd0, 1'b0};
    V[7]  = '{7'b1100011, 3'b000, 1'b0, 32'd8, 32'd9, 0, 0,
              32'd8, 32'd9, 4'd1, 1'b0};
    V[8]  = '{OP, 3'b010, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6,
              32'd0, 32'd0, 4'd0, 1'b1};
    V[9]  = '{7'b0001111, 3'b000, 1'b0, 32'd3, 32'd4,
              32'd5, 32'd6,
              32'd0, 32'd0, 4'd0, 1'b1};
    V[10] = '{OP, 3'b111, 1'b0, 32'hF0, 32'h3C, 0, 0,
              32'hF0, 32'h3C, 4'd2, 1'b0};
    V[11] = '{OP, 3'b110, 1'b0, 32'hF0, 32'h3C, 0, 0,
              32'hF0, 32'h3C, 4'd3, 1'b0};
    V[12] = '{OPI, 3'b100, 1'b0, 32'hAAAA, 0, 32'hFFFF, 0,
              32'hAAAA, 32'hFFFF, 4'd4, 1'b0};
    V[13] = '{OP, 3'b101, 1'b0, 32'h12, 32'h21, 0, 0,
              32'h12, 32'd1, 4'd6, 1'b0};
    V[14] = '{7'b0000011, 3'b010, 1'b0, 32'h1000, 0,
              32'hFFFF_FFFC, 0,
              32'h1000, 32'hFFFF_FFFC, 4'd0, 1'b0};
    V[15] = '{7'b0100011, 3'b010, 1'b0, 32'h2000, 32'h77,
              32'h10, 0,
              32'h2000, 32'h10, 4'd0, 1'b0};
    V[16] = '{7'b1100111, 3'b000, 1'b0, 32'd5, 0,
              32'd8, 32'h80,
              32'h80, 32'd4, 4'd0, 1'b0};
    V[17] = '{OPI, 3'b011, 1'b0, 32'd3, 0, 32'd4, 0,
              32'd0, 32'd0, 4'd0, 1'b1};
    V[18] = '{OP, 3'b000, 1'b0, 32'd4, 32'd6, 0, 0,
              32'd4, 32'd6, 4'd0, 1'b0};
    V[19] = '{OPI, 3'b001, 1'b0, 32'd1, 0, 32'h25, 0,
              32'd1, 32'd5, 4'd5, 1'b0};

    repeat (2) @(posedge clk);
    #2;
    chk_reset("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    out_ready = 1'b1;
    send(0);
    chk("lat_ov", out_valid, 1);
    chk("lat_a", out_a, 32'd10);
    chk("lat_b", out_b, 32'd3);
    chk("lat_sel", out_sel, 4'd1);
    chk("lat_ill", out_illegal, 0);
    @(posedge clk);
    #1;
    chk("lat_ov_next", out_valid, 0);

    for (int i = 1; i < 20; i++) send(i);
    repeat (3) @(posedge clk);
    #1;

    out_ready = 1'b0;
    fork
      begin
        send(10);
        send(11);
        send(12);
        send(13);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_ir", in_ready, 0);
        chk("bp_sel", out_sel, 4'd2);
        repeat (3) @(negedge clk);
        chk("bp_ir_hold", in_ready, 0);
        chk("bp_sel_hold", out_sel, 4'd2);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    done = 0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          send(int'($urandom_range(0, 19)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("drain_q", q.size(), 0);

    out_ready = 1'b0;
    send(0);
    send(1);
    @(negedge clk);
    chk("skid_ir", in_ready, 0);
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(4);
    chk("post_ov", out_valid, 1);
    chk("post_b", out_b, 32'h1234_5000);
    @(posedge clk);
    #1;
    chk("post_ov_next", out_valid, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
